// File: rtl/cmd_queue_pkg.sv
// Shared command-queue types: processor count, instruction opcodes and the
// packed command word that travels from the producer to the issuer.
package cmd_queue_pkg;

  localparam int PROC_COUNT = 4;
  localparam int PROC_ID_W  = $clog2(PROC_COUNT);
  localparam int OPERAND_W  = 16;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_MUL   = 4'h4,
    OP_JUMP  = 4'h5,
    OP_SYNC  = 4'h6,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e                opcode;
    logic [PROC_ID_W-1:0]   proc_id;
    logic [OPERAND_W-1:0]   operand;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cmd_queue_mem.sv
// Command storage: DEPTH x W register array, synchronous write and
// asynchronous (fall-through) read. Contents are not reset.
module cmd_queue_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cmd_queue.sv
// Command queue between a producer and an issuer, with a counter of issued
// tasks that have not yet reported completion and sticky error flags.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OUT_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_wr,
  input  logic [CMD_W-1:0]          i_wr_cmd,
  output logic                      o_full,
  input  logic                      i_rd,
  output logic [CMD_W-1:0]          o_cmd,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count,
  input  logic                      i_finished_task,
  output logic [OUT_W-1:0]          o_outstanding,
  output logic                      o_idle,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [OUT_W-1:0] r_outstanding;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_out_max;
  logic w_out_zero;

  // Handshake: a push is accepted when i_wr is high and the queue is not
  // full; a pop is accepted when i_rd is high and the queue is not empty.
  // Both decisions use only registered occupancy, so full/empty never
  // depend combinationally on the requests in the same cycle.
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_wr_acc   = i_wr & ~w_full;
  assign w_rd_acc   = i_rd & ~w_empty;
  assign w_out_max  = (r_outstanding == {OUT_W{1'b1}});
  assign w_out_zero = (r_outstanding == '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A pop and a finish in the same cycle cancel out, even at a saturation limit.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_outstanding <= '0;
    end else if (w_rd_acc && !i_finished_task) begin
      if (!w_out_max) begin
        r_outstanding <= r_outstanding + OUT_W'(1);
      end
    end else if (i_finished_task && !w_rd_acc) begin
      if (!w_out_zero) begin
        r_outstanding <= r_outstanding - OUT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_wr && w_full) begin
        r_overflow <= 1'b1;
      end
      if (i_rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  cmd_queue_mem #(
    .DEPTH (DEPTH),
    .W     (CMD_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_wr_cmd),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_cmd)
  );

  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_count       = r_count;
  assign o_outstanding = r_outstanding;
  assign o_idle        = w_empty & w_out_zero;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

endmodule

// File: doc/cmd_queue.md
CMD_QUEUE -- requirements
Module: cmd_queue

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of command entries; it is a power of two and at least 2.
REQ-002 Parameter OUT_W, default 8, SHALL set the width of the outstanding-task counter.
REQ-003 i_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rstn  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_wr  in  1  SHALL request a push of i_wr_cmd (producer side).
REQ-006 i_wr_cmd  in  $bits(cmd_t)  SHALL be the command to push.
REQ-007 o_full  out  1  SHALL be high when count == DEPTH.
REQ-008 i_rd  in  1  SHALL request a pop (issuer side, one-cycle pulse per command).
REQ-009 o_cmd  out  $bits(cmd_t)  SHALL present the head entry, first-word fall-through.
REQ-010 o_empty  out  1  SHALL be high when count == 0.
REQ-011 o_count  out  $clog2(DEPTH)+1  SHALL give the current occupancy.
REQ-012 i_finished_task  in  1  SHALL be a one-cycle pulse marking that one issued task completed.
REQ-013 o_outstanding  out  OUT_W  SHALL count popped commands not yet finished.
REQ-014 o_idle  out  1  SHALL be high when o_empty and o_outstanding == 0.
REQ-015 o_overflow  out  1  SHALL be a sticky flag for a rejected write.
REQ-016 o_underflow  out  1  SHALL be a sticky flag for a rejected read.

Function
REQ-017 Write accepted = i_wr && !o_full; the accepted command SHALL be stored at wr_ptr, and wr_ptr SHALL advance modulo DEPTH.
REQ-018 Write while o_full SHALL be dropped and SHALL set o_overflow, even if i_rd pops in the same cycle.
REQ-019 Read accepted = i_rd && !o_empty; rd_ptr SHALL advance modulo DEPTH, and o_cmd SHALL show the next entry in the following cycle.
REQ-020 Read while o_empty SHALL be ignored (pointers and count unchanged) and SHALL set o_underflow, even if a write occurs in the same cycle.
REQ-021 o_cmd SHALL equal the head entry whenever !o_empty; its value is don't-care when empty.
REQ-022 Latency: a command written into an empty queue in cycle N SHALL deassert o_empty and appear on o_cmd in cycle N+1.
REQ-023 Count update: +1 on accepted write only, -1 on accepted read only, unchanged when both are accepted in the same cycle.
REQ-024 Simultaneous accepted read and write at any non-empty, non-full occupancy SHALL preserve FIFO order.
REQ-025 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated entry.
REQ-026 o_outstanding SHALL update as follows:
  - +1 on accepted read.
  - -1 on i_finished_task.
  - Unchanged when both occur in the same cycle.
REQ-027 o_outstanding SHALL saturate at 0 (an extra finish is ignored) and at 2^OUT_W-1 (an extra pop is not counted).
REQ-028 o_full, o_empty, o_count, o_idle SHALL be derived from registered state only, with no combinational path from i_wr/i_rd.
REQ-029 o_overflow and o_underflow SHALL remain set until reset.

Reset
REQ-030 On i_rstn low, asynchronously: pointers = 0, count = 0, o_outstanding = 0, o_overflow = 0, o_underflow = 0.
REQ-031 Reset values of derived outputs: o_empty = 1, o_full = 0, o_idle = 1, o_count = 0; storage contents need not be cleared.
REQ-032 Reset asserted mid-operation SHALL discard all queued commands and all outstanding counts.

Structure
REQ-033 cmd_t, PROC_COUNT and the instruction typedefs SHALL come from the shared package/defines file; this block defines no new shared types.
REQ-034 Storage SHALL be a single sub-module, cmd_queue_mem: DEPTH x $bits(cmd_t), synchronous write, asynchronous read.
REQ-035 Control (pointers, count, outstanding counter, flags) SHALL reside in cmd_queue.

Verification
REQ-036 Reset, then push cmds A,B,C on consecutive cycles, then hold i_rd high for 3 cycles -> o_cmd = A,B,C in order; o_empty = 1 after the third pop; o_count sequence 1,2,3,2,1,0.
REQ-037 Push 8 commands (DEPTH=8) -> o_full = 1, o_count = 8; a 9th push -> dropped, o_overflow = 1, o_count stays 8.
REQ-038 Pop while empty -> o_underflow = 1, o_count = 0, pointers unchanged; o_overflow stays 0.
REQ-039 Sustained simultaneous push/pop at count 4 for 20 cycles (crossing pointer wrap) -> count stays 4; output order matches input order exactly.
REQ-040 Pop 3 commands, then pulse i_finished_task 3 times, including one cycle where pop and finish coincide -> o_outstanding = 1,2,3,3,2,1,0 as applicable; o_idle = 1 only at the end.
REQ-041 Assert i_rstn low mid-burst with count 5 and outstanding 2 -> immediately o_empty = 1, o_count = 0, o_outstanding = 0, flags cleared.
